// File: rtl/agc_timepulse_seq.sv
// Timepulse sequencer: divides CLOCK into four phases per timepulse, sequences NUM_TP
// one-hot timepulses per MCT, with GOJAM restart, monitor stop/step and overflow flags.
module agc_timepulse_seq #(
  parameter int NUM_TP = 12,
  parameter int DIV    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              SIM_RST,
  input  logic              GOJAM,
  input  logic              MSTP,
  input  logic              MSTRTP,
  input  logic              WL15,
  input  logic              WL16,
  output logic [NUM_TP-1:0] T,
  output logic [3:0]        PHS,
  output logic              RT,
  output logic              WT,
  output logic              CT,
  output logic              MCT_END,
  output logic [CNT_W-1:0]  MCT_COUNT,
  output logic              STOP,
  output logic              OVF_n,
  output logic              UNF_n
);

  localparam int TP_W = $clog2(NUM_TP);
  localparam int DV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic [TP_W-1:0] tp;
  logic [1:0]      ph;
  logic [DV_W-1:0] presc;
  logic            mstrtp_q;
  logic            tick;
  logic            last_tp;
  logic            run;

  assign run     = (state == RUN);
  assign tick    = run && (presc == DV_W'(DIV - 1));
  assign last_tp = (tp == TP_W'(NUM_TP - 1));

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state     <= RUN;
      tp        <= TP_W'(NUM_TP - 1);
      ph        <= 2'd0;
      presc     <= '0;
      mstrtp_q  <= 1'b1;
      MCT_END   <= 1'b0;
      MCT_COUNT <= '0;
      OVF_n     <= 1'b1;
      UNF_n     <= 1'b1;
    end else begin
      mstrtp_q <= MSTRTP;
      MCT_END  <= 1'b0;
      if (GOJAM) begin
        state <= RUN;
        tp    <= TP_W'(NUM_TP - 1);
        ph    <= 2'd0;
        presc <= '0;
        OVF_n <= 1'b1;
        UNF_n <= 1'b1;
      end else if (state == HALT) begin
        // Resume either because stop was released or on a step edge.
        if (!MSTP || (MSTRTP && !mstrtp_q)) begin
          state <= RUN;
          tp    <= '0;
          ph    <= 2'd0;
          presc <= '0;
        end
      end else begin
        presc <= tick ? '0 : presc + DV_W'(1);
        if (tick) begin
          if (ph == 2'd3) begin
            OVF_n <= ~(WL16 & ~WL15);
            UNF_n <= ~(~WL16 & WL15);
            ph    <= 2'd0;
            if (last_tp) begin
              tp        <= '0;
              MCT_END   <= 1'b1;
              MCT_COUNT <= MCT_COUNT + CNT_W'(1);
              if (MSTP) state <= HALT;
            end else begin
              tp <= tp + TP_W'(1);
            end
          end else begin
            ph <= ph + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    T   = '0;
    PHS = '0;
    if (run) begin
      T[tp]   = 1'b1;
      PHS[ph] = 1'b1;
    end
  end

  assign RT   = run && (ph == 2'd1);
  assign WT   = run && (ph == 2'd2);
  assign CT   = run && (ph == 2'd3);
  assign STOP = (state == HALT);

endmodule

// File: doc/agc_timepulse_seq.md
Name: agc_timepulse_seq

Overview:
- Parametrised, behavioural successor to the gate-level timer's timepulse section.
- Divides CLOCK into four phases per timepulse and sequences NUM_TP one-hot timepulses per memory cycle time (MCT).
- Adds GOJAM restart, monitor stop / single-step, an MCT counter and registered overflow/underflow flags from WL16/WL15.
- Feeds control-pulse and sequence-generator logic.

Parameters:
- NUM_TP, 12, timepulses per MCT (>=2).
- DIV, 1, CLOCK cycles per phase (>=1).
- CNT_W, 16, width of MCT_COUNT.

Ports:
- CLOCK  input  1  system clock; all logic on rising edge.
- SIM_RST  input  1  synchronous, active-high reset.
- GOJAM  input  1  level restart request.
- MSTP  input  1  monitor stop request (level).
- MSTRTP  input  1  monitor start / step; rising edge acts.
- WL15  input  1  write-bus bit 15.
- WL16  input  1  write-bus bit 16.
- T  output  NUM_TP  one-hot timepulse; bit0 = T01.
- PHS  output  4  one-hot phase within timepulse.
- RT  output  1  read strobe, phase 1.
- WT  output  1  write strobe, phase 2.
- CT  output  1  clear strobe, phase 3.
- MCT_END  output  1  one-clock pulse at each MCT boundary.
- MCT_COUNT  output  CNT_W  completed MCTs, modulo 2^CNT_W.
- STOP  output  1  sequencer halted.
- OVF_n  output  1  low = overflow latched.
- UNF_n  output  1  low = underflow latched.

Behaviour:
- Interface: one clock, CLOCK; reset SIM_RST is synchronous and active-high.
- Reset values:
  - state RUN, tp=NUM_TP-1, ph=0, prescaler=0.
  - Outputs: T=1<<(NUM_TP-1), PHS=4'b0001, RT=WT=CT=0, MCT_END=0, MCT_COUNT=0, STOP=0, OVF_n=UNF_n=1.
  - MSTRTP edge register resets to 1, so MSTRTP held high through reset produces no step.
- Priority: SIM_RST > GOJAM > stop/step > normal advance.
- Tick: prescaler counts 0..DIV-1; tick = (prescaler==DIV-1) in RUN.
- RUN advance:
  - On tick, ph increments.
  - At ph==3, ph goes to 0 and tp increments.
  - At tp==NUM_TP-1 and ph==3 (MCT boundary): tp goes to 0, MCT_END=1 for exactly one clock (the clock after the boundary tick), MCT_COUNT increments and wraps.
- Outputs are decoded from registered state, with zero combinational latency from state:
  - T[tp]=1; PHS[ph]=1.
  - RT=(ph==1), WT=(ph==2), CT=(ph==3); each lasts DIV clocks.
  - All are gated off in HALT.
- GOJAM high:
  - Next clock forces RUN, tp=NUM_TP-1, ph=0, prescaler=0, OVF_n=UNF_n=1.
  - No strobes and no MCT_END while GOJAM is high.
  - After release, counting resumes from T12 phase 0, so T01 begins 4*DIV clocks later.
- Stop:
  - MSTP is sampled at each MCT boundary tick. If high, the next state is HALT instead of wrapping.
  - On entering HALT: MCT_END and MCT_COUNT still update; tp=0, ph=0; T=0, PHS=0; STOP=1.
- HALT exit:
  - MSTP low, or a rising edge on MSTRTP: the next clock returns to RUN at T01 phase 0 with STOP=0.
  - No MCT_END on resume.
  - With MSTP still high, exactly one MCT runs and the block re-halts (single step).
  - An MSTRTP edge during RUN is ignored.
- OVF/UNF sampling, on a tick with ph==3:
  - OVF_n <= ~(WL16 & ~WL15)
  - UNF_n <= ~(~WL16 & WL15)
  - Flags hold between samples; they are not sampled in HALT.
- Reset mid-cycle, including in HALT, returns all state to reset values on the next clock.

Test Plan:
- Reset, DIV=1, NUM_TP=12, MSTP=0 -> clocks 0-3 T=12'h800 with PHS 1,2,4,8; clock 4 T=12'h001, PHS=1, MCT_END=1; MCT_COUNT=1 at clock 4 and 2 at clock 52.
- DIV=3 -> RT high 3 clocks starting clock 3 after reset, WT clocks 6-8, CT clocks 9-11; T01 at clock 12.
- GOJAM high at T05 phase 2 for 5 clocks -> next clock T=12'h800, PHS=1, strobes 0; after release T01 appears 4 clocks later; MCT_COUNT unchanged by the abort.
- MSTP=1 held -> at the next boundary STOP=1, T=0, MCT_END pulses once; MSTRTP 0->1 -> exactly 48 clocks of RUN (T01..T12) then STOP=1 again, MCT_COUNT +1; MSTP->0 -> resumes at T01.
- WL16=1, WL15=0 during CT of T03 -> OVF_n=0 from the following clock; WL16=0, WL15=1 at the next CT -> OVF_n=1, UNF_n=0; GOJAM -> both 1.
- NUM_TP=3, CNT_W=2 -> MCT of 12 clocks; MCT_COUNT wraps 3->0 on the fourth boundary.
